sync_debounce: RTL and testbench
================================

// Module: sync_debounce
// PURPOSE
//  Debounces and edge-detects a signal already brought into the clk domain by the
//  two-flop synchronizer; sits directly downstream of it. Publishes a stable level
//  plus single-cycle rise/fall pulses for control logic (buttons, strap pins, slow
//  status lines). Input is already synchronous; this block adds no synchronization.
// PARAMETERS
//  STABLE_CYCLES  1000  consecutive differing samples required to accept a new level (>=1)
//  RESET_LEVEL    1'b0  value of db_level while and after reset
//  GLITCH_W       8     width of glitch counter (only with DEBOUNCE_GLITCH_CNT_EN)
//  CNT_W          $clog2(STABLE_CYCLES+1)  derived localparam, not overridable
// PORTS
//  clk         in   1         clock; sole clock domain
//  rst         in   1         reset, synchronous, active-high
//  sync_in     in   1         synchronized input (from 2-flop synchronizer)
//  db_level    out  1         debounced level
//  rise_pulse  out  1         1-cycle pulse, db_level 0->1
//  fall_pulse  out  1         1-cycle pulse, db_level 1->0
//  busy        out  1         high while a candidate change is being qualified
//  glitch_cnt  out  GLITCH_W  rejected-bounce count (only with DEBOUNCE_GLITCH_CNT_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge): db_level=RESET_LEVEL, pulses=0, busy=0, cnt=0,
//    state=IDLE, glitch_cnt=0. All outputs registered.
//  - FSM states IDLE, SETTLE. busy == (state==SETTLE).
//  - IDLE: sample sync_in==db_level -> stay, cnt=0. sample differs -> cnt=1;
//    if STABLE_CYCLES==1 accept immediately (see accept), else -> SETTLE.
//  - SETTLE: sample differs -> cnt+1; when cnt+1==STABLE_CYCLES accept.
//    Sample equals db_level -> bounce: cnt=0, -> IDLE, glitch_cnt+1 (saturating).
//  - Accept: at the edge sampling the STABLE_CYCLES-th consecutive differing value,
//    db_level toggles, matching pulse =1 for exactly that cycle, cnt=0, -> IDLE.
//  - Latency: STABLE_CYCLES edges from first differing sample to db_level change;
//    STABLE_CYCLES=1 degenerates to a 1-cycle register plus edge detect.
//  - rise_pulse and fall_pulse never both high; pulses never back-to-back for
//    STABLE_CYCLES>1 (minimum spacing STABLE_CYCLES cycles).
//  - Counter cannot wrap: CNT_W holds STABLE_CYCLES; cnt never exceeds it.
//  - Reset mid-SETTLE abandons candidate: no pulse, no glitch increment, full
//    STABLE_CYCLES qualification required after release.
//  - rst has priority over every other event in the same cycle.
// CONFIGURATION
//  DEBOUNCE_GLITCH_CNT_EN defined: glitch_cnt port and counter present; counts
//    SETTLE->IDLE bounce exits, saturates at 2**GLITCH_W-1, cleared only by rst.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - debounce_pkg: state_t enum {IDLE, SETTLE}; default localparams for
//    STABLE_CYCLES, RESET_LEVEL, GLITCH_W.
//  - One sub-module db_sat_counter (param W; inc, clr -> q, saturating), used for
//    the qualification counter and the glitch counter. FSM + edge logic inline.
// TESTING  (STABLE_CYCLES=4, RESET_LEVEL=0, GLITCH_W=2 unless noted)
//  1 Reset: rst=1 3 cycles with sync_in=1 -> db_level=0, pulses=0, busy=0, glitch_cnt=0.
//  2 Clean rise: sync_in 0->1 held -> busy high 3 cycles, db_level=1 and rise_pulse=1
//    on 4th sampling edge, rise_pulse low next cycle; hold 1 for 20 cycles, no more pulses.
//  3 Bounce: sync_in=1 for 3 cycles then 0 -> db_level stays 0, no pulse,
//    glitch_cnt=1, busy falls; repeat 5x -> glitch_cnt saturates at 3.
//  4 Clean fall from db_level=1: sync_in=0 held -> fall_pulse 1 cycle on 4th edge.
//  5 Reset mid-SETTLE: 2 differing samples then rst=1 1 cycle, sync_in held 1 ->
//    no pulse; db_level=1 only 4 edges after rst release.
//  6 STABLE_CYCLES=1: toggle sync_in every cycle -> db_level follows with 1-cycle
//    latency, alternating rise/fall pulses each cycle, glitch_cnt stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the sync_debounce block.
// The optional glitch counter is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int   DEF_STABLE_CYCLES = 1000;
    localparam logic DEF_RESET_LEVEL   = 1'b0;
    localparam int   DEF_GLITCH_W      = 8;

endpackage

// File: rtl/db_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for both the qualification counter and the glitch counter.
module db_sat_counter
    import debounce_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Q_MAX = {W{1'b1}};

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (inc && (q_reg != Q_MAX)) begin
            q_next = q_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/sync_debounce.sv
// Debouncer with rise/fall pulse outputs for an already-synchronised input.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating rejected-bounce counter.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic RESET_LEVEL   = DEF_RESET_LEVEL
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int   GLITCH_W      = DEF_GLITCH_W
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync_in,
    output logic                db_level,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Counter value on the edge that samples the final qualifying value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             level_reg;
    logic             level_next;
    logic             rise_reg;
    logic             rise_next;
    logic             fall_reg;
    logic             fall_next;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             accept;
    logic             differ;
    logic [CNT_W-1:0] cnt;

    assign differ = (sync_in != level_reg);

    db_sat_counter #(
        .W (CNT_W)
    ) u_qual_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .q   (cnt)
    );

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!differ) begin
                    cnt_clr = 1'b1;
                end else if (STABLE_CYCLES == 1) begin
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc    = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!differ) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
        if (accept) begin
            level_next = ~level_reg;
            rise_next  = ~level_reg;
            fall_next  = level_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            level_reg <= RESET_LEVEL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign db_level   = level_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign busy       = (state_reg == SETTLE);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // A bounce is any matching sample seen while a candidate is being qualified.
    logic glitch_inc;
    assign glitch_inc = (state_reg == SETTLE) && !differ;

    db_sat_counter #(
        .W (GLITCH_W)
    ) u_glitch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (glitch_inc),
        .clr (1'b0),
        .q   (glitch_cnt)
    );
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: a 4-cycle instance and a 1-cycle instance driven by
// directed and random steps, checked against a run-length reference model.
module tb_sync_debounce;

    localparam int GMAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_in4 = 1'b0;
    logic       sync_in1 = 1'b0;
    logic       lvl4, rise4, fall4, busy4;
    logic       lvl1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [1:0] glitch4, glitch1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_debounce #(
        .STABLE_CYCLES (4),
        .RESET_LEVEL   (1'b0)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .GLITCH_W      (2)
`endif
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in4),
        .db_level   (lvl4),
        .rise_pulse (rise4),
        .fall_pulse (fall4),
        .busy       (busy4)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch4)
`endif
    );

    sync_debounce #(
        .STABLE_CYCLES (1),
        .RESET_LEVEL   (1'b0)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .GLITCH_W      (2)
`endif
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in1),
        .db_level   (lvl1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .busy       (busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch1)
`endif
    );

    // Reference: count consecutive samples that disagree with the accepted level.
    typedef struct {
        bit lvl;
        bit rise;
        bit fall;
        int run;
        int glitch;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t mstep(mdl_t m, bit s, bit r, int n);
        mdl_t o;
        o = m;
        o.rise = 1'b0;
        o.fall = 1'b0;
        if (r) begin
            o.lvl    = 1'b0;
            o.run    = 0;
            o.glitch = 0;
        end else if (s != m.lvl) begin
            o.run = m.run + 1;
            if (o.run == n) begin
                o.lvl  = s;
                o.rise = s;
                o.fall = !s;
                o.run  = 0;
            end
        end else begin
            if (m.run > 0 && m.glitch < GMAX) o.glitch = m.glitch + 1;
            o.run = 0;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v4, input bit v1, input bit r);
        @(negedge clk);
        sync_in4 = v4;
        sync_in1 = v1;
        rst      = r;
        @(posedge clk);
        m4 = mstep(m4, v4, r, 4);
        m1 = mstep(m1, v1, r, 1);
        #1;
        chk("lvl4", 32'(lvl4), 32'(m4.lvl));
        chk("rise4", 32'(rise4), 32'(m4.rise));
        chk("fall4", 32'(fall4), 32'(m4.fall));
        chk("busy4", 32'(busy4), 32'(m4.run > 0));
        chk("lvl1", 32'(lvl1), 32'(m1.lvl));
        chk("rise1", 32'(rise1), 32'(m1.rise));
        chk("fall1", 32'(fall1), 32'(m1.fall));
        chk("busy1", 32'(busy1), 32'(m1.run > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch4", 32'(glitch4), 32'(m4.glitch));
        chk("glitch1", 32'(glitch1), 32'(m1.glitch));
`endif
        $display("step rst=%0b in4=%0b in1=%0b | lvl4=%0b r=%0b f=%0b b=%0b | lvl1=%0b r=%0b f=%0b",
                 r, v4, v1, lvl4, rise4, fall4, busy4, lvl1, rise1, fall1);
    endtask

    initial begin
        int  rises;
        bit  v1;
        bit  prev1;
        bit  v4;
        int  run_left;

        m4 = '{lvl: 1'b0, rise: 1'b0, fall: 1'b0, run: 0, glitch: 0};
        m1 = m4;

        // Reset held with the input high: nothing may leak through.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        chk("reset_lvl4", 32'(lvl4), 32'd0);
        chk("reset_busy4", 32'(busy4), 32'd0);
        chk("reset_rise4", 32'(rise4), 32'd0);

        // Clean rise, then hold.
        rises = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            if (i == 2) begin
                chk("rise_pre_lvl", 32'(lvl4), 32'd0);
                chk("rise_pre_busy", 32'(busy4), 32'd1);
            end
            if (i == 3) begin
                chk("rise_at4_lvl", 32'(lvl4), 32'd1);
                chk("rise_at4_pulse", 32'(rise4), 32'd1);
            end
            if (i == 4) chk("rise_after", 32'(rise4), 32'd0);
            rises += int'(rise4);
        end
        chk("rise_once", 32'(rises), 32'd1);

        // Clean fall.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom), 1'b0);
            if (i == 2) chk("fall_pre_lvl", 32'(lvl4), 32'd1);
            if (i == 3) chk("fall_at4_pulse", 32'(fall4), 32'd1);
            if (i == 4) chk("fall_after", 32'(fall4), 32'd0);
        end

        // Repeated bounces: three differing samples then a matching one.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
            step(1'b0, 1'($urandom), 1'b0);
            chk("bounce_lvl", 32'(lvl4), 32'd0);
            chk("bounce_busy", 32'(busy4), 32'd0);
            chk("bounce_rise", 32'(rise4), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            chk("bounce_glitch", 32'(glitch4), (k + 1 < 3) ? 32'(k + 1) : 32'd3);
`endif
        end

        // Reset in the middle of qualification.
        step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'($urandom), 1'b1);
        chk("midrst_busy", 32'(busy4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            chk("midrst_lvl", 32'(lvl4), (i == 3) ? 32'd1 : 32'd0);
            chk("midrst_rise", 32'(rise4), (i == 3) ? 32'd1 : 32'd0);
        end

        // Single-cycle instance: toggle every cycle.
        prev1 = lvl1;
        for (int i = 0; i < 20; i++) begin
            v1 = (i % 2) == 0;
            step(1'b1, v1, 1'b0);
            chk("fast_lvl", 32'(lvl1), 32'(v1));
            chk("fast_pulse", 32'(rise1 | fall1), 32'(v1 != prev1));
            prev1 = v1;
        end

        // Random runs with occasional reset.
        run_left = 0;
        v4 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (run_left == 0) begin
                v4       = 1'($urandom);
                run_left = $urandom_range(1, 6);
            end
            run_left--;
            step(v4, 1'($urandom), $urandom_range(0, 49) == 0);
            chk("rand_excl4", 32'(rise4 & fall4), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
